// File: rtl/cp0.sv
// ---------------------------------------------------------------------------
// cp0 -- MIPS-style coprocessor 0 subset (SR, Cause, EPC, PRId)
//
// Handles interrupt and exception entry, eret, and mtc0/mfc0 access for a
// single-issue pipeline whose commit point is the M stage.
//
// Ports
//   clk         : single clock; all state changes on its rising edge
//   reset_n     : asynchronous, active-low reset
//   a1          : mfc0 read register number   -> dout (combinational)
//   a2/din/we   : mtc0 write register number / data / enable
//   pc_in       : PC of the instruction at the commit point
//   bd_in       : that instruction sits in a branch delay slot
//   exc_req     : synchronous exception flagged for pc_in
//   exccode_in  : ExcCode of that exception
//   hwint       : level-sensitive external interrupt lines
//   eretop      : eret is committing
//   intreq      : redirect the PC to the handler (combinational)
//   epc         : return address for eret
//   dout        : mfc0 read data
//
// Build option
//   CP0_BD_EN   : when defined, Cause.BD is captured and EPC points at the
//                 branch (pc_in - 4) for delay-slot faults. When undefined,
//                 Cause.BD reads 0 and bd_in is ignored.
// ---------------------------------------------------------------------------
module cp0 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic        exc_req,
  input  logic [4:0]  exccode_in,
  input  logic [5:0]  hwint,
  input  logic        eretop,
  output logic        intreq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  localparam logic [31:0] PRID_VALUE = 32'h4D49_5053;

  // architectural state
  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [29:0] r_epc;

  logic        w_cause_bd;
  logic [29:0] w_epc_entry;
  logic        w_int_pend;
  logic        w_exc_take;
  logic        w_intreq;
  logic        w_sr_wr;
  logic        w_epc_wr;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused_pc_lsb;

  // the low PC bits never reach EPC (word-aligned return address)
  assign w_unused_pc_lsb = ^pc_in[1:0];

`ifdef CP0_BD_EN
  logic r_cause_bd;

  assign w_cause_bd  = r_cause_bd;
  // a delay-slot fault returns to the branch so the branch is re-executed
  assign w_epc_entry = bd_in ? (pc_in[31:2] - 30'd1) : pc_in[31:2];

  // Cause.BD: captured on every exception/interrupt entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause_bd <= 1'b0;
    end else if (w_intreq) begin
      r_cause_bd <= bd_in;
    end else begin
      r_cause_bd <= r_cause_bd;
    end
  end
`else
  logic w_unused_bd;

  assign w_unused_bd = bd_in;
  assign w_cause_bd  = 1'b0;
  assign w_epc_entry = pc_in[31:2];
`endif

  // entry conditions; EXL masks both sources so handlers never nest.
  // intreq is gated by reset_n so a stray exc_req cannot redirect during reset.
  assign w_int_pend = (|(hwint & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_take = exc_req & ~r_sr_exl;
  assign w_intreq   = reset_n & (w_int_pend | w_exc_take);
  assign intreq     = w_intreq;

  // an mtc0 in the same cycle as an entry is squashed along with its instruction
  assign w_sr_wr  = we & (a2 == 5'd12) & ~w_intreq;
  assign w_epc_wr = we & (a2 == 5'd14) & ~w_intreq;

  // SR: entry sets EXL, eret clears it (winning over mtc0), mtc0 loads IM/EXL/IE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr_im  <= 6'd0;
      r_sr_exl <= 1'b0;
      r_sr_ie  <= 1'b0;
    end else begin
      if (w_sr_wr) begin
        r_sr_im <= din[15:10];
        r_sr_ie <= din[0];
      end else begin
        r_sr_im <= r_sr_im;
        r_sr_ie <= r_sr_ie;
      end
      if (w_intreq) begin
        r_sr_exl <= 1'b1;
      end else if (eretop) begin
        r_sr_exl <= 1'b0;
      end else if (w_sr_wr) begin
        r_sr_exl <= din[1];
      end else begin
        r_sr_exl <= r_sr_exl;
      end
    end
  end

  // Cause: IP mirrors hwint every edge; ExcCode captured on entry (0 for interrupts)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
    end else begin
      r_cause_ip <= hwint;
      if (w_intreq) begin
        r_cause_exc <= w_int_pend ? 5'd0 : exccode_in;
      end else begin
        r_cause_exc <= r_cause_exc;
      end
    end
  end

  // EPC: loaded on entry, or by mtc0 when no entry happens this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_epc <= 30'd0;
    end else if (w_intreq) begin
      r_epc <= w_epc_entry;
    end else if (w_epc_wr) begin
      r_epc <= din[31:2];
    end else begin
      r_epc <= r_epc;
    end
  end

  assign w_sr    = {16'h0000, r_sr_im, 8'h00, r_sr_exl, r_sr_ie};
  assign w_cause = {w_cause_bd, 15'h0000, r_cause_ip, 3'b000, r_cause_exc, 2'b00};
  assign epc     = {r_epc, 2'b00};

  // mfc0 read mux; unimplemented register numbers read zero
  always_comb begin
    dout = 32'h0000_0000;
    case (a1)
      5'd12:   dout = w_sr;
      5'd13:   dout = w_cause;
      5'd14:   dout = {r_epc, 2'b00};
      5'd15:   dout = PRID_VALUE;
      default: dout = 32'h0000_0000;
    endcase
  end

endmodule
